// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller.
// One 4-bit CLA slice is reused for every nibble, least-significant nibble first.
// Vectors use bit 0 = MSB, so nibble k sits at [WIDTH-4-4k : WIDTH-1-4k].
// WIDTH must be a multiple of 4 and at least 8.

// 4-bit carry-lookahead slice, purely combinational; bit 0 = MSB, bit 3 = LSB.
module Adder_CLA_4bit (
    input  logic [0:3] a,
    input  logic [0:3] b,
    input  logic       inC,
    output logic [0:3] s,
    output logic       outC
);
    logic [0:3] g;
    logic [0:3] p;
    logic [0:3] cin;

    assign g = a & b;
    assign p = a ^ b;

    // Carry into each bit position, all expanded directly from inC.
    always_comb begin
        cin[3] = inC;
        cin[2] = g[3] | (p[3] & inC);
        cin[1] = g[2] | (p[2] & g[3]) | (p[2] & p[3] & inC);
        cin[0] = g[1] | (p[1] & g[2]) | (p[1] & p[2] & g[3]) | (p[1] & p[2] & p[3] & inC);
        outC   = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2]) | (p[0] & p[1] & p[2] & g[3])
               | (p[0] & p[1] & p[2] & p[3] & inC);
    end

    assign s = p ^ cin;
endmodule

// State table:
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   RUN   | one nibble per clock, k = nibble index
//   DONE  | result valid, done=1, ready=1 (back-to-back accept allowed)
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             ready,
    output logic             done,
    output logic [0:WIDTH-1] s,
    output logic             c,
    output logic             v
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic [0:WIDTH-1] a_reg;
    logic [0:WIDTH-1] b_reg;
    logic [0:WIDTH-1] work;
    logic [0:WIDTH-1] work_nxt;
    logic             carry;
    logic [0:3]       nib_s;
    logic             nib_c;
    logic             last;
    int               base;

    assign base = WIDTH - 4 - 4 * int'(k);
    assign last = (k == K_LAST);

    Adder_CLA_4bit u_cla (
        .a    (a_reg[base +: 4]),
        .b    (b_reg[base +: 4]),
        .inC  (carry),
        .s    (nib_s),
        .outC (nib_c)
    );

    // Working register with the current nibble merged in; on the last nibble this is the full sum.
    always_comb begin
        work_nxt              = work;
        work_nxt[base +: 4]   = nib_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, nibble iteration and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else if (ready && start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            k     <= '0;
        end else if (state == RUN) begin
            work  <= work_nxt;
            carry <= nib_c;
            if (last) begin
                s <= work_nxt;
                c <= nib_c;
                v <= (a_reg[0] == b_reg[0]) && (nib_s[0] != a_reg[0]);
            end else begin
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that performs a WIDTH-bit add or subtract by time-sharing a single `Adder_CLA_4bit` slice, one nibble per clock, least-significant nibble first. It is the area-reduced arithmetic path for VCPU-32 configurations that trade adder width for latency, and the reference controller for any unit sharing a 4-bit CLA slice. It owns the operand/result registers, the inter-nibble carry and the start/done handshake. The CLA slice itself is instantiated internally and is not modified.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8. N = WIDTH/4 nibbles.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled on a rising edge while ready=1.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  [0:WIDTH-1]  operand A, bit 0 = MSB; sampled with start.
- b  in  [0:WIDTH-1]  operand B, bit 0 = MSB; sampled with start.
- ready  out  1  controller can accept start.
- done  out  1  one-cycle pulse; result outputs valid.
- s  out  [0:WIDTH-1]  result, registered.
- c  out  1  carry out of the MSB nibble. For sub, 1 = no borrow.
- v  out  1  two's-complement signed overflow.

## Operation
- States are IDLE, RUN and DONE. A nibble counter k runs from 0 to N-1.
- ready = 1 in IDLE and in DONE, and 0 in RUN.
- **Accept.** On an edge with start=1 and ready=1:
  - latch A ← a and B' ← (sub ? ~b : b);
  - set carry register ← sub and k ← 0;
  - go to RUN.
- **RUN, each edge.** The slice is driven with:
  - .a = A[WIDTH-4-4k : WIDTH-1-4k];
  - .b = the same bits of B';
  - .inC = carry register.
- **RUN, on that edge.** The working nibble at the same position ← .s, and carry register ← .outC.
- **RUN, last nibble.** If k = N-1, go to DONE. Otherwise k ← k+1.
- **RUN to DONE edge.** Load the outputs from the working register and the MSB nibble results:
  - s ← working register;
  - c ← final outC;
  - v ← (A[0] == B'[0]) && (sum[0] != A[0]).
- **DONE.** done = 1 for exactly this one cycle. Next edge: if start=1, accept (back-to-back); otherwise go to IDLE.
- s, c and v hold the previous result throughout RUN. They change only on the edge entering DONE and then hold until the next completion.
- start while ready=0 is ignored; no queuing. Changes to a, b or sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. The carry/overflow definitions above are the only flag outputs.

## Timing
- Latency: done is high in the cycle following edge T+N, where T is the accepting edge. For WIDTH=32 that is 8 RUN edges, with done visible after the 8th.
- Throughput: one operation per N+1 cycles. The accept edge of the next operation can coincide with the DONE cycle.
- Reset, asserted at any time including mid-RUN, takes effect asynchronously:
  - state = IDLE, k = 0, carry register = 0;
  - ready = 1, done = 0;
  - s = 0, c = 0, v = 0.
- An operation in flight at reset is aborted with no done pulse.
- The first accept is possible on the first rising edge after rst deasserts.
- The slice is purely combinational. No added pipeline stage between the counter mux and the working register.

## Test plan
1. **Add, no carry.** a=0x0000000A, b=0x00000005, sub=0, start for 1 cycle:
   - ready low for 8 cycles;
   - done pulse 9 edges after accept;
   - s=0x0000000F, c=0, v=0.
2. **Carry ripple and signed overflow.**
   - a=0xFFFFFFFF + b=0x00000001 → s=0x00000000, c=1, v=0.
   - Then a=0x7FFFFFFF + b=0x00000001 → s=0x80000000, c=0, v=1.
3. **Subtract.**
   - 5−5 → s=0, c=1, v=0.
   - 0−1 → s=0xFFFFFFFF, c=0, v=0.
   - 0x80000000−1 → s=0x7FFFFFFF, c=1, v=1.
4. **Back-to-back and ignored start.**
   - Hold start=1 continuously with operands changed every cycle. Only the operands present on accept edges are used.
   - Exactly one done per 9 cycles, with correct sums.
   - s stays at the prior result during RUN.
5. **Reset mid-operation.** Assert rst at RUN k=4:
   - immediately ready=1, done=0, s=0, c=0, v=0;
   - no done pulse follows;
   - next accepted 0x12345678+0x11111111 → s=0x23456789.
6. **Width parameter.** WIDTH=8, 0xF0+0x20 → s=0x10, c=1, v=0, with done 3 edges after accept.
